ex_mem_wb_pipe: RTL and testbench
=================================

Name: ex_mem_wb_pipe

Overview:
- Upstream neighbour of the forwarding unit: the EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS pipeline.
- Produces the forwarding unit's destination and write-enable inputs: Rd/WE from EX/MEM, RW/WB from MEM/WB.
- Also produces the forwarded values: mem_alu and wb_data.
- Adds pipeline hold, bubble insertion and load-use stall request generation. Loads in EX cannot be forwarded from MEM, so they stall instead.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, memory read data)
REG_W, 5, register-index width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-high reset
hold  in  1  freeze both stages (memory wait / halt)
ex_bubble  in  1  load a bubble into EX/MEM instead of the EX inputs
ex_rd  in  REG_W  EX-stage destination register
ex_we  in  1  EX-stage register write enable
ex_memtoreg  in  1  EX-stage instruction is a load
ex_memwrite  in  1  EX-stage instruction is a store (sw/sh)
ex_alu  in  DATA_W  EX ALU result / memory address
ex_sdata  in  DATA_W  EX store data (already forwarded)
id_ra  in  REG_W  ID-stage source register A
id_rb  in  REG_W  ID-stage source register B
mem_rdata  in  DATA_W  data-memory read data for the instruction in MEM
Rd  out  REG_W  EX/MEM destination register
WE  out  1  EX/MEM register write enable
mem_alu  out  DATA_W  EX/MEM ALU result (MEM forward value, memory address)
mem_memtoreg  out  1  EX/MEM load flag
mem_memwrite  out  1  EX/MEM store enable to data memory
mem_sdata  out  DATA_W  EX/MEM store data
RW  out  REG_W  MEM/WB destination register
WB  out  1  MEM/WB register write enable
wb_data  out  DATA_W  MEM/WB writeback value (WB forward value)
stall_req  out  1  load-use stall request to IF/ID and hazard control

Behaviour:
- Reset (async, rst=1): all registered outputs go to 0 immediately and stay 0 while rst is high. No stale WE/WB/mem_memwrite may be seen after reset.
- Register update on posedge clk, evaluated in priority order:
  - hold=1: both stages keep their values. ex_bubble is ignored and must be re-asserted after the hold.
  - ex_bubble=1: EX/MEM loads all zeros (Rd=0, WE=0, memtoreg=0, memwrite=0, data=0).
  - Otherwise EX/MEM captures the ex_* inputs. WE is forced to 0 when ex_rd==0, so $0 is never a forwarding source.
- MEM/WB advances whenever hold=0, regardless of ex_bubble:
  - RW<=Rd
  - WB<=WE
  - wb_data<=mem_memtoreg ? mem_rdata : mem_alu
- Latency: ex_* appears on Rd/WE/mem_* 1 cycle after capture. It appears on RW/WB/wb_data 2 cycles after capture, with no holds in between.
- A bubble propagates: Rd/WE=0 for one cycle, then RW/WB=0 the next.
- stall_req is combinational from the EX inputs:
  - asserted when ex_memtoreg & ex_we & ex_rd!=0 & (ex_rd==id_ra | ex_rd==id_rb) & !ex_bubble
  - independent of hold
  - the external hazard logic asserts ex_bubble in the following cycle
- Two consecutive writes to the same register: Rd holds the younger one and RW the older one. Priority between them belongs to the forwarding unit; this block only presents both.
- Reset asserted mid-operation: in-flight instructions are discarded. No retention across reset.

Optional Feature:
PIPE_STAT_EN:
- Defined: adds outputs bubble_cnt[31:0] and hold_cnt[31:0]. Both reset to 0.
- bubble_cnt increments on each clock edge where EX/MEM loads a bubble (hold=0 & ex_bubble=1).
- hold_cnt increments on each edge with hold=1.
- Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor counter exists, and the pipeline behaviour is identical.

Test Plan:
- Reset: drive rst=1 mid-stream with ex_we=1, ex_rd=8 -> Rd, WE, RW, WB, wb_data and mem_memwrite are 0 immediately, before any clock edge.
- Basic flow: ex_rd=9, ex_we=1, ex_alu=0x1234 for one cycle -> next cycle Rd=9, WE=1, mem_alu=0x1234; cycle after RW=9, WB=1, wb_data=0x1234.
- Load path: ex_memtoreg=1, ex_rd=10, mem_rdata=0xCAFEF00D during MEM -> wb_data=0xCAFEF00D, not ex_alu.
- Load-use: ex_memtoreg=1, ex_we=1, ex_rd=5, id_rb=5 -> stall_req=1. Then with ex_rd=0 -> stall_req=0. Next cycle ex_bubble=1 -> Rd=0, WE=0, then RW=0, WB=0.
- Hold: assert hold 3 cycles while Rd=7 and RW=6, with ex_bubble=1 during the hold -> all outputs unchanged for 3 cycles, no bubble inserted. With PIPE_STAT_EN: hold_cnt=3, bubble_cnt=0.
- $0 write: ex_rd=0, ex_we=1 -> WE=0, then WB=0. Store: ex_memwrite=1, ex_sdata=0xAA -> mem_memwrite=1, mem_sdata=0xAA for exactly one cycle.

Source files
------------

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with hold, bubble insertion and load-use stall request.
// Optional statistics counters enabled by defining PIPE_STAT_EN.
module ex_mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              ex_bubble,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_we,
  input  logic              ex_memtoreg,
  input  logic              ex_memwrite,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_sdata,
  input  logic [REG_W-1:0]  id_ra,
  input  logic [REG_W-1:0]  id_rb,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_W-1:0]  Rd,
  output logic              WE,
  output logic [DATA_W-1:0] mem_alu,
  output logic              mem_memtoreg,
  output logic              mem_memwrite,
  output logic [DATA_W-1:0] mem_sdata,
  output logic [REG_W-1:0]  RW,
  output logic              WB,
  output logic [DATA_W-1:0] wb_data,
`ifdef PIPE_STAT_EN
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       hold_cnt,
`endif
  output logic              stall_req
);

  logic [REG_W-1:0]  rd_q, rd_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              memtoreg_q, memtoreg_d;
  logic              memwrite_q, memwrite_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [REG_W-1:0]  rw_q, rw_d;
  logic              wb_q, wb_d;
  logic [DATA_W-1:0] wbdata_q, wbdata_d;

  // Next-state: hold freezes both stages, bubble only zeroes EX/MEM.
  always_comb begin
    rd_d       = rd_q;
    we_d       = we_q;
    alu_d      = alu_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    sdata_d    = sdata_q;
    rw_d       = rw_q;
    wb_d       = wb_q;
    wbdata_d   = wbdata_q;
    if (!hold) begin
      if (ex_bubble) begin
        rd_d       = '0;
        we_d       = 1'b0;
        alu_d      = '0;
        memtoreg_d = 1'b0;
        memwrite_d = 1'b0;
        sdata_d    = '0;
      end else begin
        rd_d       = ex_rd;
        // $0 must never look like a forwarding source
        we_d       = ex_we & (ex_rd != '0);
        alu_d      = ex_alu;
        memtoreg_d = ex_memtoreg;
        memwrite_d = ex_memwrite;
        sdata_d    = ex_sdata;
      end
      rw_d     = rd_q;
      wb_d     = we_q;
      wbdata_d = memtoreg_q ? mem_rdata : alu_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      we_q       <= 1'b0;
      alu_q      <= '0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      sdata_q    <= '0;
      rw_q       <= '0;
      wb_q       <= 1'b0;
      wbdata_q   <= '0;
    end else begin
      rd_q       <= rd_d;
      we_q       <= we_d;
      alu_q      <= alu_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      sdata_q    <= sdata_d;
      rw_q       <= rw_d;
      wb_q       <= wb_d;
      wbdata_q   <= wbdata_d;
    end
  end

  assign Rd           = rd_q;
  assign WE           = we_q;
  assign mem_alu      = alu_q;
  assign mem_memtoreg = memtoreg_q;
  assign mem_memwrite = memwrite_q;
  assign mem_sdata    = sdata_q;
  assign RW           = rw_q;
  assign WB           = wb_q;
  assign wb_data      = wbdata_q;

  // A load result is only available after MEM, so a dependent ID instruction must stall.
  assign stall_req = ex_memtoreg & ex_we & (ex_rd != '0) &
                     ((ex_rd == id_ra) | (ex_rd == id_rb)) & ~ex_bubble;

`ifdef PIPE_STAT_EN
  logic [31:0] bubble_cnt_q, hold_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      if (!hold && ex_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (hold)               hold_cnt_q   <= hold_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed testbench for ex_mem_wb_pipe; inputs change and outputs are sampled 1ns after each rising edge.
module tb_ex_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold, ex_bubble, ex_we, ex_memtoreg, ex_memwrite;
  logic [4:0]  ex_rd, id_ra, id_rb;
  logic [31:0] ex_alu, ex_sdata, mem_rdata;
  logic [4:0]  Rd, RW;
  logic        WE, WB, mem_memtoreg, mem_memwrite, stall_req;
  logic [31:0] mem_alu, mem_sdata, wb_data;
`ifdef PIPE_STAT_EN
  logic [31:0] bubble_cnt, hold_cnt;
  logic [31:0] bub0, hold0;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ex_mem_wb_pipe #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .ex_bubble(ex_bubble),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_alu(ex_alu), .ex_sdata(ex_sdata), .id_ra(id_ra), .id_rb(id_rb),
    .mem_rdata(mem_rdata), .Rd(Rd), .WE(WE), .mem_alu(mem_alu),
    .mem_memtoreg(mem_memtoreg), .mem_memwrite(mem_memwrite), .mem_sdata(mem_sdata),
    .RW(RW), .WB(WB), .wb_data(wb_data),
`ifdef PIPE_STAT_EN
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt),
`endif
    .stall_req(stall_req)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold = 0; ex_bubble = 0; ex_we = 0; ex_memtoreg = 0; ex_memwrite = 0;
    ex_rd = 0; id_ra = 0; id_rb = 0; ex_alu = 0; ex_sdata = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    vecs++; if (Rd !== 5'd0 || WE !== 1'b0 || RW !== 5'd0 || WB !== 1'b0) begin errs++; $display("FAIL reset_init: Rd=%0d WE=%0b RW=%0d WB=%0b want all 0", Rd, WE, RW, WB); end
    step(); step();
    rst = 0;
    ex_rd = 8; ex_we = 1; ex_alu = 32'h88; ex_memwrite = 1;
    step();
    step();
    vecs++; if (RW !== 5'd8 || WB !== 1'b1 || WE !== 1'b1) begin errs++; $display("FAIL reset_prefill: RW=%0d WB=%0b WE=%0b want 8 1 1", RW, WB, WE); end
    rst = 1;
    #1;
    vecs++; if (Rd !== 5'd0 || WE !== 1'b0 || RW !== 5'd0 || WB !== 1'b0) begin errs++; $display("FAIL reset_async_regs: Rd=%0d WE=%0b RW=%0d WB=%0b want all 0", Rd, WE, RW, WB); end
    vecs++; if (wb_data !== 32'd0 || mem_memwrite !== 1'b0 || mem_alu !== 32'd0) begin errs++; $display("FAIL reset_async_data: wb_data=%h memwrite=%0b mem_alu=%h want 0", wb_data, mem_memwrite, mem_alu); end
    step();
    vecs++; if (WE !== 1'b0 || WB !== 1'b0 || mem_memwrite !== 1'b0) begin errs++; $display("FAIL reset_held: WE=%0b WB=%0b memwrite=%0b want 0", WE, WB, mem_memwrite); end
    idle_inputs();
    rst = 0;
    step();
  endtask

  task automatic test_basic_flow();
    ex_rd = 9; ex_we = 1; ex_alu = 32'h1234;
    step();
    idle_inputs();
    vecs++; if (Rd !== 5'd9 || WE !== 1'b1 || mem_alu !== 32'h1234) begin errs++; $display("FAIL flow_exmem: Rd=%0d WE=%0b mem_alu=%h want 9 1 1234", Rd, WE, mem_alu); end
    step();
    vecs++; if (RW !== 5'd9 || WB !== 1'b1 || wb_data !== 32'h1234) begin errs++; $display("FAIL flow_memwb: RW=%0d WB=%0b wb_data=%h want 9 1 1234", RW, WB, wb_data); end
    vecs++; if (Rd !== 5'd0 || WE !== 1'b0) begin errs++; $display("FAIL flow_next: Rd=%0d WE=%0b want 0 0", Rd, WE); end
  endtask

  task automatic test_load();
    ex_rd = 10; ex_we = 1; ex_memtoreg = 1; ex_alu = 32'h100;
    step();
    idle_inputs();
    mem_rdata = 32'hCAFEF00D;
    vecs++; if (mem_memtoreg !== 1'b1 || mem_alu !== 32'h100) begin errs++; $display("FAIL load_exmem: memtoreg=%0b mem_alu=%h want 1 100", mem_memtoreg, mem_alu); end
    step();
    mem_rdata = 0;
    vecs++; if (wb_data !== 32'hCAFEF00D || RW !== 5'd10 || WB !== 1'b1) begin errs++; $display("FAIL load_wb: wb_data=%h RW=%0d WB=%0b want cafef00d 10 1", wb_data, RW, WB); end
  endtask

  task automatic test_load_use();
    ex_memtoreg = 1; ex_we = 1; ex_rd = 5; id_ra = 3; id_rb = 5;
    #1;
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL luse_rb: stall_req=%0b want 1", stall_req); end
    ex_rd = 0;
    #1;
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL luse_r0: stall_req=%0b want 0", stall_req); end
    ex_rd = 5; id_ra = 5; id_rb = 7; hold = 1;
    #1;
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL luse_hold: stall_req=%0b want 1", stall_req); end
    hold = 0; ex_we = 0;
    #1;
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL luse_nowe: stall_req=%0b want 0", stall_req); end
    ex_we = 1; ex_alu = 32'h500; mem_rdata = 32'h0;
    step();
    ex_bubble = 1;
    #1;
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL luse_bubble_mask: stall_req=%0b want 0", stall_req); end
    step();
    idle_inputs();
    vecs++; if (Rd !== 5'd0 || WE !== 1'b0 || mem_memtoreg !== 1'b0) begin errs++; $display("FAIL luse_bubble_ex: Rd=%0d WE=%0b memtoreg=%0b want 0", Rd, WE, mem_memtoreg); end
    vecs++; if (RW !== 5'd5 || WB !== 1'b1) begin errs++; $display("FAIL luse_load_wb: RW=%0d WB=%0b want 5 1", RW, WB); end
    step();
    vecs++; if (RW !== 5'd0 || WB !== 1'b0) begin errs++; $display("FAIL luse_bubble_wb: RW=%0d WB=%0b want 0 0", RW, WB); end
  endtask

  task automatic test_hold();
    ex_rd = 6; ex_we = 1; ex_alu = 32'h66;
    step();
    ex_rd = 7; ex_alu = 32'h77;
    step();
`ifdef PIPE_STAT_EN
    bub0 = bubble_cnt; hold0 = hold_cnt;
`endif
    hold = 1; ex_bubble = 1; ex_rd = 9; ex_alu = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (Rd !== 5'd7 || WE !== 1'b1 || mem_alu !== 32'h77) begin errs++; $display("FAIL hold_exmem[%0d]: Rd=%0d WE=%0b mem_alu=%h want 7 1 77", i, Rd, WE, mem_alu); end
      vecs++; if (RW !== 5'd6 || WB !== 1'b1 || wb_data !== 32'h66) begin errs++; $display("FAIL hold_memwb[%0d]: RW=%0d WB=%0b wb_data=%h want 6 1 66", i, RW, WB, wb_data); end
    end
`ifdef PIPE_STAT_EN
    vecs++; if (hold_cnt - hold0 !== 32'd3 || bubble_cnt - bub0 !== 32'd0) begin errs++; $display("FAIL hold_stats: holds=%0d bubbles=%0d want 3 0", hold_cnt - hold0, bubble_cnt - bub0); end
`endif
    idle_inputs();
    step();
    vecs++; if (RW !== 5'd7 || wb_data !== 32'h77 || Rd !== 5'd0) begin errs++; $display("FAIL hold_release: RW=%0d wb_data=%h Rd=%0d want 7 77 0", RW, wb_data, Rd); end
  endtask

  task automatic test_zero_reg_and_store();
    ex_rd = 0; ex_we = 1; ex_alu = 32'h55;
    step();
    ex_we = 0; ex_alu = 32'h40; ex_memwrite = 1; ex_sdata = 32'hAA;
    vecs++; if (WE !== 1'b0 || Rd !== 5'd0 || mem_alu !== 32'h55) begin errs++; $display("FAIL r0_we: WE=%0b Rd=%0d mem_alu=%h want 0 0 55", WE, Rd, mem_alu); end
    step();
    idle_inputs();
    vecs++; if (WB !== 1'b0 || wb_data !== 32'h55) begin errs++; $display("FAIL r0_wb: WB=%0b wb_data=%h want 0 55", WB, wb_data); end
    vecs++; if (mem_memwrite !== 1'b1 || mem_sdata !== 32'hAA || mem_alu !== 32'h40) begin errs++; $display("FAIL store_mem: memwrite=%0b sdata=%h addr=%h want 1 aa 40", mem_memwrite, mem_sdata, mem_alu); end
    step();
    vecs++; if (mem_memwrite !== 1'b0) begin errs++; $display("FAIL store_once: memwrite=%0b want 0", mem_memwrite); end
  endtask

  task automatic test_back_to_back();
    ex_rd = 3; ex_we = 1; ex_alu = 32'h1;
    step();
    ex_alu = 32'h2;
    step();
    idle_inputs();
    vecs++; if (Rd !== 5'd3 || mem_alu !== 32'h2 || RW !== 5'd3 || wb_data !== 32'h1) begin errs++; $display("FAIL b2b: Rd=%0d mem_alu=%h RW=%0d wb_data=%h want 3 2 3 1", Rd, mem_alu, RW, wb_data); end
`ifdef PIPE_STAT_EN
    bub0 = bubble_cnt;
    ex_bubble = 1;
    step(); step();
    ex_bubble = 0;
    vecs++; if (bubble_cnt - bub0 !== 32'd2) begin errs++; $display("FAIL bubble_cnt: delta=%0d want 2", bubble_cnt - bub0); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_load();
    test_load_use();
    test_hold();
    test_zero_reg_and_store();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
